// File: rtl/fabric_bitstream_pkg.sv
// rtl/fabric_bitstream_pkg.sv - shared types and constants for the bitstream framing checker
package fabric_bitstream_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HEADER  = 2'd1,
    PAYLOAD = 2'd2,
    CHECK   = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    NONE    = 2'd0,
    HDR     = 2'd1,
    TIMEOUT = 2'd2,
    CSUM    = 2'd3
  } err_code_e;

  localparam int          HDR_LEN_W         = 16;
  localparam int          HDR_CHK_W         = 16;
  localparam int          TIMER_W           = 20;
  localparam logic [31:0] DEFAULT_SYNC_WORD = 32'hFAB0_FAB1;

endpackage

// File: rtl/fabric_bitstream_checker_if.sv
// rtl/fabric_bitstream_checker_if.sv - word stream, abort and status bundle of the bitstream checker
interface fabric_bitstream_checker_if;
  logic [31:0] in_data_i;
  logic        in_valid_i;
  logic        abort_i;
  logic [31:0] out_data_o;
  logic        out_valid_o;
  logic        busy_o;
  logic        done_o;
  logic        error_o;
  logic [1:0]  err_code_o;

  modport master (
    output in_data_i, in_valid_i, abort_i,
    input  out_data_o, out_valid_o, busy_o, done_o, error_o, err_code_o
  );

  modport slave (
    input  in_data_i, in_valid_i, abort_i,
    output out_data_o, out_valid_o, busy_o, done_o, error_o, err_code_o
  );
endinterface

// File: rtl/fabric_bitstream_timeout.sv
// rtl/fabric_bitstream_timeout.sv - saturating idle watchdog; hit when count reaches limit
module fabric_bitstream_timeout #(
  parameter int W = 20
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         enable,
  input  logic [W-1:0] limit,
  output logic         hit
);
  logic [W-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

  // A word arriving this cycle always beats the watchdog.
  assign hit = enable && !clear && (count >= limit);
endmodule

// File: rtl/fabric_bitstream_checker.sv
// rtl/fabric_bitstream_checker.sv - sync hunt, header check and payload forwarding; trailer sum under FABRIC_BITSTREAM_CHECKSUM_EN
module fabric_bitstream_checker
  import fabric_bitstream_pkg::*;
#(
  parameter logic [31:0] SYNC_WORD      = DEFAULT_SYNC_WORD,
  parameter logic [15:0] MAX_WORDS      = 16'h0A92,
  parameter int          TIMEOUT_CYCLES = 1_000_000
) (
  input logic                        clk_i,
  input logic                        rst_i,
  fabric_bitstream_checker_if.slave  bus
);
  localparam logic [1:0]         S_IDLE        = IDLE;
  localparam logic [1:0]         S_HEADER      = HEADER;
  localparam logic [1:0]         S_PAYLOAD     = PAYLOAD;
`ifdef FABRIC_BITSTREAM_CHECKSUM_EN
  localparam logic [1:0]         S_CHECK       = CHECK;
`endif
  localparam logic [TIMER_W-1:0] TIMEOUT_LIMIT = TIMER_W'(TIMEOUT_CYCLES);

  logic [1:0]           state;
  logic [HDR_LEN_W-1:0] remaining;
  logic [31:0]          out_data;
  logic                 out_valid;
  logic                 done;
  logic                 error;
  logic [1:0]           err_code;
  logic                 timer_hit;
`ifdef FABRIC_BITSTREAM_CHECKSUM_EN
  logic [31:0]          sum;
`endif

  logic [HDR_LEN_W-1:0] hdr_len;
  logic [HDR_CHK_W-1:0] hdr_chk;
  logic                 hdr_ok;

  assign hdr_len = bus.in_data_i[HDR_LEN_W-1:0];
  assign hdr_chk = bus.in_data_i[31 -: HDR_CHK_W];
  assign hdr_ok  = (hdr_chk == ~hdr_len) && (hdr_len != '0) && (hdr_len <= MAX_WORDS);

  fabric_bitstream_timeout #(.W(TIMER_W)) u_timeout (
    .clk    (clk_i),
    .rst    (rst_i),
    .clear  (bus.in_valid_i || (state == S_IDLE)),
    .enable (state != S_IDLE),
    .limit  (TIMEOUT_LIMIT),
    .hit    (timer_hit)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state     <= S_IDLE;
      remaining <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
      err_code  <= NONE;
`ifdef FABRIC_BITSTREAM_CHECKSUM_EN
      sum       <= '0;
`endif
    end else begin
      out_valid <= 1'b0;
      done      <= 1'b0;
      if (bus.abort_i) begin
        state <= S_IDLE;
      end else if (timer_hit) begin
        state    <= S_IDLE;
        error    <= 1'b1;
        err_code <= TIMEOUT;
      end else if (bus.in_valid_i) begin
        case (state)
          S_IDLE: begin
            if (bus.in_data_i == SYNC_WORD) begin
              state    <= S_HEADER;
              error    <= 1'b0;
              err_code <= NONE;
            end
          end
          S_HEADER: begin
            if (hdr_ok) begin
              remaining <= hdr_len;
              state     <= S_PAYLOAD;
`ifdef FABRIC_BITSTREAM_CHECKSUM_EN
              sum       <= '0;
`endif
            end else begin
              state    <= S_IDLE;
              error    <= 1'b1;
              err_code <= HDR;
            end
          end
          S_PAYLOAD: begin
            out_data  <= bus.in_data_i;
            out_valid <= 1'b1;
            remaining <= remaining - 1'b1;
`ifdef FABRIC_BITSTREAM_CHECKSUM_EN
            sum       <= sum + bus.in_data_i;
            if (remaining == 16'd1) state <= S_CHECK;
`else
            if (remaining == 16'd1) begin
              state <= S_IDLE;
              done  <= 1'b1;
            end
`endif
          end
`ifdef FABRIC_BITSTREAM_CHECKSUM_EN
          S_CHECK: begin
            state <= S_IDLE;
            if (bus.in_data_i == sum) begin
              done <= 1'b1;
            end else begin
              error    <= 1'b1;
              err_code <= CSUM;
            end
          end
`endif
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  assign bus.out_data_o  = out_data;
  assign bus.out_valid_o = out_valid;
  assign bus.busy_o      = (state != S_IDLE);
  assign bus.done_o      = done;
  assign bus.error_o     = error;
  assign bus.err_code_o  = err_code;
endmodule

// File: tb/tb_fabric_bitstream_checker.sv
// tb/tb_fabric_bitstream_checker.sv - directed vector bench for fabric_bitstream_checker
module tb_fabric_bitstream_checker;
  localparam logic [31:0] SYNC = 32'hFAB0_FAB1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  fabric_bitstream_checker_if bif ();

  fabric_bitstream_checker #(.TIMEOUT_CYCLES(16)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bif)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        v;
    logic [31:0] d;
    logic        a;
    logic        ov;
    logic [31:0] od;
    logic        done;
    logic        busy;
    logic        err;
    logic [1:0]  code;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(string n, logic v, logic [31:0] d, logic a, logic ov,
                              logic [31:0] od, logic dn, logic b, logic e, logic [1:0] c);
    vec_t r;
    r.name = n; r.v = v; r.d = d; r.a = a; r.ov = ov; r.od = od;
    r.done = dn; r.busy = b; r.err = e; r.code = c;
    return r;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic step(logic v, logic [31:0] d, logic a);
    bif.in_valid_i = v;
    bif.in_data_i  = d;
    bif.abort_i    = a;
    @(posedge clk);
    #1;
    bif.in_valid_i = 1'b0;
    bif.abort_i    = 1'b0;
  endtask

  initial begin
    logic [31:0] sum;
    int          extra;
    bit          done_seen;

    bif.in_valid_i = 1'b0;
    bif.in_data_i  = '0;
    bif.abort_i    = 1'b0;

    vecs.push_back(mk("stray",     1, 32'h1234_5678, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk("sync",      1, SYNC,          0, 0, 0, 0, 1, 0, 0));
    vecs.push_back(mk("hdr",       1, 32'hFFFC_0003, 0, 0, 0, 0, 1, 0, 0));
    vecs.push_back(mk("w1",        1, 32'h1,         0, 1, 1, 0, 1, 0, 0));
    vecs.push_back(mk("w2",        1, 32'h2,         0, 1, 2, 0, 1, 0, 0));
`ifdef FABRIC_BITSTREAM_CHECKSUM_EN
    vecs.push_back(mk("w3",        1, 32'h3,         0, 1, 3, 0, 1, 0, 0));
    vecs.push_back(mk("trailer",   1, 32'h6,         0, 0, 0, 1, 0, 0, 0));
`else
    vecs.push_back(mk("w3",        1, 32'h3,         0, 1, 3, 1, 0, 0, 0));
`endif
    vecs.push_back(mk("idle",      0, 32'h0,         0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk("sync2",     1, SYNC,          0, 0, 0, 0, 1, 0, 0));
    vecs.push_back(mk("bad_hdr",   1, 32'h0000_0003, 0, 0, 0, 0, 0, 1, 1));
    vecs.push_back(mk("ignored",   1, 32'h5,         0, 0, 0, 0, 0, 1, 1));
    vecs.push_back(mk("abort_idl", 0, 32'h0,         1, 0, 0, 0, 0, 1, 1));
    vecs.push_back(mk("sync3",     1, SYNC,          0, 0, 0, 0, 1, 0, 0));
    vecs.push_back(mk("hdr_big",   1, 32'hF56C_0A93, 0, 0, 0, 0, 0, 1, 1));
    vecs.push_back(mk("sync4",     1, SYNC,          0, 0, 0, 0, 1, 0, 0));
    vecs.push_back(mk("hdr_zero",  1, 32'hFFFF_0000, 0, 0, 0, 0, 0, 1, 1));
    vecs.push_back(mk("sync5",     1, SYNC,          0, 0, 0, 0, 1, 0, 0));
    vecs.push_back(mk("hdr2",      1, 32'hFFFD_0002, 0, 0, 0, 0, 1, 0, 0));
    vecs.push_back(mk("sync_data", 1, SYNC,          0, 1, SYNC, 0, 1, 0, 0));
    vecs.push_back(mk("abort_col", 1, 32'hDEAD_BEEF, 1, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk("post",      1, 32'h9,         0, 0, 0, 0, 0, 0, 0));

    repeat (3) @(posedge clk);
    #1;
    chk("rst_ov",   {31'b0, bif.out_valid_o}, 0);
    chk("rst_od",   bif.out_data_o, 0);
    chk("rst_busy", {31'b0, bif.busy_o}, 0);
    chk("rst_done", {31'b0, bif.done_o}, 0);
    chk("rst_err",  {31'b0, bif.error_o}, 0);
    chk("rst_code", {30'b0, bif.err_code_o}, 0);
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i]) begin
      step(vecs[i].v, vecs[i].d, vecs[i].a);
      chk({vecs[i].name, "_ov"},   {31'b0, bif.out_valid_o}, {31'b0, vecs[i].ov});
      if (vecs[i].ov) chk({vecs[i].name, "_od"}, bif.out_data_o, vecs[i].od);
      chk({vecs[i].name, "_done"}, {31'b0, bif.done_o}, {31'b0, vecs[i].done});
      chk({vecs[i].name, "_busy"}, {31'b0, bif.busy_o}, {31'b0, vecs[i].busy});
      chk({vecs[i].name, "_err"},  {31'b0, bif.error_o}, {31'b0, vecs[i].err});
      chk({vecs[i].name, "_code"}, {30'b0, bif.err_code_o}, {30'b0, vecs[i].code});
    end

    // Longest legal frame
    step(1, SYNC, 0);
    step(1, 32'hF56D_0A92, 0);
    chk("max_hdr_busy", {31'b0, bif.busy_o}, 1);
    chk("max_hdr_err",  {31'b0, bif.error_o}, 0);
    sum = 0;
    for (int i = 0; i < 2706; i++) begin
      logic [31:0] w;
      w = i * 3 + 7;
      sum += w;
      step(1, w, 0);
      chk("max_ov", {31'b0, bif.out_valid_o}, 1);
      chk("max_od", bif.out_data_o, w);
`ifdef FABRIC_BITSTREAM_CHECKSUM_EN
      chk("max_done", {31'b0, bif.done_o}, 0);
`else
      chk("max_done", {31'b0, bif.done_o}, (i == 2705) ? 1 : 0);
`endif
    end
`ifdef FABRIC_BITSTREAM_CHECKSUM_EN
    step(1, sum, 0);
    chk("max_trl_done", {31'b0, bif.done_o}, 1);
`endif
    chk("max_end_busy", {31'b0, bif.busy_o}, 0);
    chk("max_end_err",  {31'b0, bif.error_o}, 0);

    // Stalled frame: two of four words, then silence
    step(1, SYNC, 0);
    step(1, 32'hFFFB_0004, 0);
    step(1, 32'hA, 0);
    chk("to_w1", bif.out_data_o, 32'hA);
    step(1, 32'hB, 0);
    chk("to_w2", bif.out_data_o, 32'hB);
    extra = 0;
    done_seen = 0;
    for (int i = 0; i < 40; i++) begin
      step(0, 0, 0);
      if (bif.out_valid_o) extra++;
      if (bif.done_o) done_seen = 1;
      if (i == 9) chk("to_busy_mid", {31'b0, bif.busy_o}, 1);
    end
    chk("to_extra", extra, 0);
    chk("to_done",  {31'b0, done_seen}, 0);
    chk("to_err",   {31'b0, bif.error_o}, 1);
    chk("to_code",  {30'b0, bif.err_code_o}, 2);
    chk("to_busy",  {31'b0, bif.busy_o}, 0);

    // Wrapping payload sum, good and bad trailer
    for (int k = 0; k < 2; k++) begin
      step(1, SYNC, 0);
      chk("cs_sync_err", {31'b0, bif.error_o}, 0);
      step(1, 32'hFFFD_0002, 0);
      step(1, 32'hFFFF_FFFF, 0);
      chk("cs_w1", bif.out_data_o, 32'hFFFF_FFFF);
      step(1, 32'h0000_0002, 0);
      chk("cs_w2", bif.out_data_o, 32'h0000_0002);
`ifdef FABRIC_BITSTREAM_CHECKSUM_EN
      chk("cs_w2_done", {31'b0, bif.done_o}, 0);
      step(1, (k == 0) ? 32'h1 : 32'h0, 0);
      chk("cs_trl_ov",   {31'b0, bif.out_valid_o}, 0);
      chk("cs_trl_done", {31'b0, bif.done_o}, (k == 0) ? 1 : 0);
      chk("cs_trl_err",  {31'b0, bif.error_o}, (k == 0) ? 0 : 1);
      chk("cs_trl_code", {30'b0, bif.err_code_o}, (k == 0) ? 0 : 3);
`else
      chk("cs_w2_done", {31'b0, bif.done_o}, 1);
      step(1, (k == 0) ? 32'h1 : 32'h0, 0);
      chk("cs_tail_ov",   {31'b0, bif.out_valid_o}, 0);
      chk("cs_tail_done", {31'b0, bif.done_o}, 0);
      chk("cs_tail_err",  {31'b0, bif.error_o}, 0);
      chk("cs_tail_code", {30'b0, bif.err_code_o}, 0);
`endif
      chk("cs_busy", {31'b0, bif.busy_o}, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
